sdram_arbiter: RTL



---
 rtl/sdram_arbiter.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Command-bus arbiter and sequencer for the SDRAM controller. The init engine
// owns the bus until init_end rises. After that, the single SDRAM
// command/address/data bus is granted to exactly one of the auto-refresh,
// write and read engines at a time. This block also contains the refresh
// interval timer that requests auto-refresh.
//
// Parameters
//   REF_CYCLES : clocks between auto-refresh requests (10-bit timer, <= 1024)
//   CMD_NOP    : {cs_n,ras_n,cas_n,we_n} driven while no engine owns the bus
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   init_end                           initialisation complete (level)
//   init_cmd/init_bank/init_addr       init engine bus
//   aref_end                           refresh engine done (1-cycle pulse)
//   aref_cmd/aref_bank/aref_addr       refresh engine bus
//   wr_req, wr_end                     write request (level) / done (pulse)
//   wr_cmd/wr_bank/wr_addr             write engine bus
//   wr_sdram_en, wr_sdram_data         write engine dq enable / data
//   rd_req, rd_end                     read request (level) / done (pulse)
//   rd_cmd/rd_bank/rd_addr             read engine bus
//   aref_en/wr_en/rd_en                grant to each engine (level)
//   sdram_cmd/sdram_bank/sdram_addr    muxed SDRAM command bus
//   sdram_dq_oe, sdram_dq_out          dq output enable / drive value
//   ref_miss                           refresh interval expired while a
//                                      refresh was still pending (pulse)
//
// Build option
//   SDRAM_ARB_RR_EN : when defined, write and read are served round-robin;
//                     otherwise write has fixed priority over read. Refresh
//                     always has absolute priority.
// -----------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int unsigned REF_CYCLES = 750,
  parameter logic [3:0]  CMD_NOP    = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_bank,
  input  logic [12:0] init_addr,

  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_bank,
  input  logic [12:0] aref_addr,

  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  input  logic        wr_sdram_en,
  input  logic [15:0] wr_sdram_data,

  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,

  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,

  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr,
  output logic        sdram_dq_oe,
  output logic [15:0] sdram_dq_out,

  output logic        ref_miss
);

  localparam logic [9:0] REF_LAST = 10'(REF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARB,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  state_t state, state_nxt;
  logic   aref_en_nxt, wr_en_nxt, rd_en_nxt;

  logic [9:0] ref_cnt;
  logic       ref_wrap;
  logic       aref_pend;
  logic       enter_aref;
  logic       wr_pick;

  // ---------------------------------------------------------------------------
  // Write/read tie-break
  // ---------------------------------------------------------------------------
`ifdef SDRAM_ARB_RR_EN
  // last_wr remembers which of write/read was granted most recently; on a tie
  // the other one wins. Resets to 0 so write wins the first tie.
  logic last_wr;

  always_comb wr_pick = wr_req && !(rd_req && last_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (state == ST_ARB) begin
      if (state_nxt == ST_WRITE)
        last_wr <= 1'b1;
      else if (state_nxt == ST_READ)
        last_wr <= 1'b0;
    end
  end
`else
  always_comb wr_pick = wr_req;
`endif

  // ---------------------------------------------------------------------------
  // Refresh interval timer
  // ---------------------------------------------------------------------------
  always_comb ref_wrap = init_end && (ref_cnt == REF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ref_cnt <= '0;
    else if (!init_end || ref_wrap)
      ref_cnt <= '0;
    else
      ref_cnt <= ref_cnt + 10'd1;
  end

  always_comb enter_aref = (state == ST_ARB) && (state_nxt == ST_AREF);

  // A wrap takes precedence over the clear so an interval that expires on the
  // very edge a refresh starts is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aref_pend <= 1'b0;
      ref_miss  <= 1'b0;
    end else begin
      ref_miss <= ref_wrap && aref_pend;
      if (ref_wrap)
        aref_pend <= 1'b1;
      else if (enter_aref)
        aref_pend <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant FSM: state and grant registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aref_en <= aref_en_nxt;
      wr_en   <= wr_en_nxt;
      rd_en   <= rd_en_nxt;
    end
  end

  // Grant FSM: next state. The grant is registered on the same edge as the
  // state change, so *_en and the owning state always move together.
  always_comb begin
    state_nxt   = state;
    aref_en_nxt = aref_en;
    wr_en_nxt   = wr_en;
    rd_en_nxt   = rd_en;

    unique case (state)
      ST_INIT: begin
        aref_en_nxt = 1'b0;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        if (init_end)
          state_nxt = ST_ARB;
      end

      ST_ARB: begin
        aref_en_nxt = 1'b0;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        if (aref_pend) begin
          state_nxt   = ST_AREF;
          aref_en_nxt = 1'b1;
        end else if (wr_pick) begin
          state_nxt = ST_WRITE;
          wr_en_nxt = 1'b1;
        end else if (rd_req) begin
          state_nxt = ST_READ;
          rd_en_nxt = 1'b1;
        end
      end

      ST_AREF: begin
        if (aref_end) begin
          state_nxt   = ST_ARB;
          aref_en_nxt = 1'b0;
        end
      end

      ST_WRITE: begin
        if (wr_end) begin
          state_nxt = ST_ARB;
          wr_en_nxt = 1'b0;
        end
      end

      ST_READ: begin
        if (rd_end) begin
          state_nxt = ST_ARB;
          rd_en_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt   = ST_INIT;
        aref_en_nxt = 1'b0;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus mux: combinational from the registered state, no added latency
  // ---------------------------------------------------------------------------
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_bank = '0;
    sdram_addr = '0;
    unique case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_bank = aref_bank;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_bank = wr_bank;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '0;
        sdram_addr = '0;
      end
    endcase
  end

  always_comb begin
    sdram_dq_oe  = (state == ST_WRITE) && wr_sdram_en;
    sdram_dq_out = wr_sdram_data;
  end

endmodule
